// File: rtl/bus_pkg.sv
// Shared constants for the simple-bus slave: state encoding, address map and
// wait-state counter sizing.
package bus_pkg;

  localparam int BUS_DATA_W = 32;
  localparam int WAIT_CNT_W = 4;
  localparam int WAIT_MAX   = (1 << WAIT_CNT_W) - 1;

  localparam logic [7:0] SLAVE0_BASE = 8'h00;
  localparam logic [7:0] SLAVE1_BASE = 8'h20;
  localparam logic [7:0] SLAVE_SPAN  = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Counter preload for the WAIT state; the zero-wait case skips WAIT entirely.
  function automatic logic [WAIT_CNT_W-1:0] wait_load(input int wc);
    if (wc > 0) return WAIT_CNT_W'(wc - 1);
    return '0;
  endfunction

endpackage

// File: rtl/bus_slave_mem.sv
// Word register array behind one bus slave: single write port, combinational
// read port, whole array cleared by the asynchronous reset.
module bus_slave_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/bus_slave.sv
// Bus responder: accepts one selected read/write, waits WAIT_CYCLES, then
// pulses s_ack for one cycle with read data on s_dout.
module bus_slave
  import bus_pkg::*;
#(
  parameter int DATA_W      = BUS_DATA_W,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_sel,
  input  logic              s_req,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_address,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout,
  output logic              s_ack,
  output logic              s_busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

  state_t                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]     dout_q, dout_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;

  logic                  wr_q;
  logic [IDX_W-1:0]      addr_q;
  logic [DATA_W-1:0]     din_q;

  logic                  accept;
  logic                  enter_ack;
  logic                  cur_wr;
  logic [IDX_W-1:0]      cur_addr;
  logic [DATA_W-1:0]     cur_din;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_rdata;

  // Upper address bits select the slave in the decoder, not a word here.
  logic unused_addr_hi;
  assign unused_addr_hi = ^s_address[ADDR_W-1:IDX_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_req && s_sel) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_ACK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states ACK is entered on the accept edge itself, so the
  // live bus fields must be used there instead of the not-yet-loaded latches.
  always_comb begin
    cur_wr    = (state_q == ST_IDLE) ? s_wr                 : wr_q;
    cur_addr  = (state_q == ST_IDLE) ? s_address[IDX_W-1:0] : addr_q;
    cur_din   = (state_q == ST_IDLE) ? s_din                : din_q;
    enter_ack = (state_d == ST_ACK) && (state_q != ST_ACK);
    mem_we    = enter_ack && cur_wr;
    dout_d    = (enter_ack && !cur_wr) ? mem_rdata : dout_q;
    ack_d     = (state_d == ST_ACK);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q   <= s_wr;
      addr_q <= s_address[IDX_W-1:0];
      din_q  <= s_din;
    end
  end

  bus_slave_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .waddr (cur_addr),
    .wdata (cur_din),
    .raddr (cur_addr),
    .rdata (mem_rdata)
  );

  assign s_dout = dout_q;
  assign s_ack  = ack_q;
  assign s_busy = busy_q;

endmodule
